// File: rtl/message_controller_pkg.sv
// Shared game package: message codes and default frame timing.
package message_controller_pkg;

  typedef enum logic [1:0] {
    MSG_NONE     = 2'b00,
    MSG_READY    = 2'b01,
    MSG_GAMEOVER = 2'b10,
    MSG_WIN      = 2'b11
  } msg_t;

  localparam int DEF_READY_FRAMES    = 120;
  localparam int DEF_HIT_FRAMES      = 60;
  localparam int DEF_MIN_SHOW_FRAMES = 90;
  localparam int DEF_BLINK_FRAMES    = 16;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_counter.sv
// Saturating startOfFrame counter with synchronous clear.
module frame_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/message_controller.sv
// Game flow FSM: level-start, hit freeze, game over and win messages.
module message_controller
  import message_controller_pkg::*;
#(
  parameter int READY_FRAMES    = DEF_READY_FRAMES,
  parameter int HIT_FRAMES      = DEF_HIT_FRAMES,
  parameter int MIN_SHOW_FRAMES = DEF_MIN_SHOW_FRAMES,
  parameter int BLINK_FRAMES    = DEF_BLINK_FRAMES
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       gameStart,
  input  logic       playerHit,
  input  logic       levelCleared,
  input  logic       livesZero,
  input  logic       lastLevel,
  input  logic       anyKey,
  output logic [1:0] message,
  output logic       gameFreeze,
  output logic       blinkOn,
  output logic       restartReq
);

  localparam int MAXF = max2(max2(READY_FRAMES, HIT_FRAMES),
                             max2(MIN_SHOW_FRAMES, BLINK_FRAMES));
  localparam int CW = $clog2(MAXF + 1);

  localparam logic [CW-1:0] READY_LAST = CW'(READY_FRAMES - 1);
  localparam logic [CW-1:0] HIT_LAST   = CW'(HIT_FRAMES - 1);
  localparam logic [CW-1:0] SHOW_MIN   = CW'(MIN_SHOW_FRAMES);
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_FRAMES - 1);

  typedef enum logic [2:0] {
    IDLE,
    READY,
    PLAYING,
    HIT,
    GAME_OVER,
    WIN
  } state_t;

  state_t        state, state_n;
  msg_t          msg_q, msg_n;
  logic          restart_n;
  logic          blink_n;
  logic          moved;
  logic          blink_wrap;
  logic [CW-1:0] cnt;
  logic [CW-1:0] bcnt;

  function automatic msg_t msg_of(state_t s);
    unique case (s)
      READY:     return MSG_READY;
      GAME_OVER: return MSG_GAMEOVER;
      WIN:       return MSG_WIN;
      default:   return MSG_NONE;
    endcase
  endfunction

  frame_counter #(.W(CW)) u_state_cnt (
    .clk    (clk),
    .resetN (resetN),
    .clear  (moved),
    .inc    (startOfFrame),
    .count  (cnt)
  );

  frame_counter #(.W(CW)) u_blink_cnt (
    .clk    (clk),
    .resetN (resetN),
    .clear  (moved || blink_wrap),
    .inc    (startOfFrame),
    .count  (bcnt)
  );

  always_comb begin
    state_n   = state;
    restart_n = 1'b0;
    unique case (state)
      IDLE:
        if (gameStart)
          state_n = READY;
      READY:
        if (startOfFrame && (cnt == READY_LAST))
          state_n = PLAYING;
      PLAYING:
        if (playerHit)
          state_n = HIT;
        else if (levelCleared)
          state_n = lastLevel ? WIN : READY;
      HIT:
        if (startOfFrame && (cnt == HIT_LAST))
          state_n = livesZero ? GAME_OVER : READY;
      GAME_OVER, WIN:
        if (anyKey && (cnt >= SHOW_MIN)) begin
          state_n   = IDLE;
          restart_n = 1'b1;
        end
      default:
        state_n = IDLE;
    endcase
  end

  // Blink restarts high on every entry; only nonzero messages blink.
  always_comb begin
    moved      = (state_n != state);
    msg_n      = msg_of(state_n);
    blink_wrap = startOfFrame && (bcnt == BLINK_LAST);
    if (moved || (msg_n == MSG_NONE))
      blink_n = 1'b1;
    else if (blink_wrap)
      blink_n = ~blinkOn;
    else
      blink_n = blinkOn;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      msg_q      <= MSG_NONE;
      gameFreeze <= 1'b1;
      blinkOn    <= 1'b1;
      restartReq <= 1'b0;
    end else begin
      state      <= state_n;
      msg_q      <= msg_n;
      gameFreeze <= (state_n != PLAYING);
      blinkOn    <= blink_n;
      restartReq <= restart_n;
    end
  end

  assign message = msg_q;

endmodule

// File: tb/tb_message_controller.sv
// Directed bench for message_controller with short frame parameters.
module tb_message_controller;

  logic       clk = 1'b0;
  logic       resetN = 1'b1;
  logic       sof = 1'b0;
  logic       gs = 1'b0;
  logic       hit = 1'b0;
  logic       lc = 1'b0;
  logic       lz = 1'b0;
  logic       last = 1'b0;
  logic       key = 1'b0;
  logic [1:0] message;
  logic       gameFreeze;
  logic       blinkOn;
  logic       restartReq;

  int total = 0;
  int bad   = 0;

  message_controller #(
    .READY_FRAMES    (4),
    .HIT_FRAMES      (3),
    .MIN_SHOW_FRAMES (5),
    .BLINK_FRAMES    (2)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (sof),
    .gameStart    (gs),
    .playerHit    (hit),
    .levelCleared (lc),
    .livesZero    (lz),
    .lastLevel    (last),
    .anyKey       (key),
    .message      (message),
    .gameFreeze   (gameFreeze),
    .blinkOn      (blinkOn),
    .restartReq   (restartReq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    sof = 1'b0;
    gs  = 1'b0;
    hit = 1'b0;
    lc  = 1'b0;
    key = 1'b0;
  endtask

  task automatic frame();
    sof = 1'b1;
    cyc();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic to_playing();
    gs = 1'b1;
    cyc();
    frames(4);
  endtask

  initial begin
    #1 resetN = 1'b0;
    #2;
    chk("rst_msg", 8'(message), 8'h0);
    chk("rst_frz", 8'(gameFreeze), 8'h1);
    chk("rst_blk", 8'(blinkOn), 8'h1);
    chk("rst_req", 8'(restartReq), 8'h0);
    cyc();
    cyc();
    resetN = 1'b1;
    cyc();

    frame();
    key = 1'b1;
    cyc();
    chk("idle_ign", 8'(message), 8'h0);
    chk("idle_frz", 8'(gameFreeze), 8'h1);

    gs = 1'b1;
    cyc();
    chk("rdy_msg", 8'(message), 8'h1);
    chk("rdy_blk0", 8'(blinkOn), 8'h1);
    frames(2);
    chk("rdy_blk2", 8'(blinkOn), 8'h0);
    frame();
    chk("rdy_f3", 8'(message), 8'h1);
    frame();
    chk("play_msg", 8'(message), 8'h0);
    chk("play_frz", 8'(gameFreeze), 8'h0);
    chk("play_blk", 8'(blinkOn), 8'h1);

    lz  = 1'b0;
    hit = 1'b1;
    lc  = 1'b1;
    cyc();
    chk("hit_msg", 8'(message), 8'h0);
    chk("hit_frz", 8'(gameFreeze), 8'h1);
    frames(2);
    chk("hit_f2", 8'(message), 8'h0);
    frame();
    chk("hit_rdy", 8'(message), 8'h1);
    frames(4);
    chk("play2", 8'(gameFreeze), 8'h0);

    last = 1'b0;
    lc   = 1'b1;
    cyc();
    chk("lvl_rdy", 8'(message), 8'h1);
    frames(4);
    chk("play3", 8'(gameFreeze), 8'h0);

    lz  = 1'b1;
    hit = 1'b1;
    cyc();
    frames(3);
    chk("go_msg", 8'(message), 8'h2);
    frames(2);
    key = 1'b1;
    cyc();
    chk("go_key2", 8'(message), 8'h2);
    chk("go_req2", 8'(restartReq), 8'h0);
    frames(3);
    key = 1'b1;
    cyc();
    chk("go_req", 8'(restartReq), 8'h1);
    chk("go_idle", 8'(message), 8'h0);
    cyc();
    chk("go_req1", 8'(restartReq), 8'h0);
    lz = 1'b0;

    to_playing();
    last = 1'b1;
    lc   = 1'b1;
    cyc();
    chk("win_msg", 8'(message), 8'h3);
    chk("win_b0", 8'(blinkOn), 8'h1);
    frame();
    chk("win_b1", 8'(blinkOn), 8'h1);
    frame();
    chk("win_b2", 8'(blinkOn), 8'h0);
    frame();
    chk("win_b3", 8'(blinkOn), 8'h0);
    frame();
    chk("win_b4", 8'(blinkOn), 8'h1);
    key = 1'b1;
    cyc();
    chk("win_key4", 8'(message), 8'h3);
    frame();
    key = 1'b1;
    cyc();
    chk("win_req", 8'(restartReq), 8'h1);
    chk("win_idle", 8'(message), 8'h0);

    to_playing();
    lc = 1'b1;
    cyc();
    frames(3);
    chk("win2_msg", 8'(message), 8'h3);
    key = 1'b1;
    #1 resetN = 1'b0;
    #1;
    chk("ar_msg", 8'(message), 8'h0);
    chk("ar_frz", 8'(gameFreeze), 8'h1);
    chk("ar_req", 8'(restartReq), 8'h0);
    cyc();
    chk("ar_req2", 8'(restartReq), 8'h0);
    resetN = 1'b1;
    last = 1'b0;
    frames(5);
    chk("ar_idle", 8'(message), 8'h0);
    gs = 1'b1;
    cyc();
    chk("ar_start", 8'(message), 8'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/message_controller.md
MESSAGE_CONTROLLER -- requirements
Module: message_controller

Interface
REQ-001 The block SHALL have parameter READY_FRAMES, default 120: frames the level-start message is shown.
REQ-002 The block SHALL have parameter HIT_FRAMES, default 60: frozen frames after a player hit.
REQ-003 The block SHALL have parameter MIN_SHOW_FRAMES, default 90: frames before a restart key is accepted in GAME_OVER/WIN.
REQ-004 The block SHALL have parameter BLINK_FRAMES, default 16: frames per blinkOn half-period.
REQ-005 The block SHALL have port clk, input, 1: system clock.
REQ-006 The block SHALL have port resetN, input, 1: asynchronous, active-low reset.
REQ-007 The block SHALL have port startOfFrame, input, 1: one-cycle pulse per video frame.
REQ-008 The block SHALL have port gameStart, input, 1: one-cycle pulse to begin play from IDLE.
REQ-009 The block SHALL have port playerHit, input, 1: one-cycle pulse when a ball hits the player.
REQ-010 The block SHALL have port levelCleared, input, 1: one-cycle pulse when the last ball is popped.
REQ-011 The block SHALL have port livesZero, input, 1: level, high when no lives remain after the hit is counted.
REQ-012 The block SHALL have port lastLevel, input, 1: level, high while the final level is being played.
REQ-013 The block SHALL have port anyKey, input, 1: one-cycle restart key pulse.
REQ-014 The block SHALL have port message, output, 2: 00 none, 01 ready, 10 game over, 11 win; consumed by the message bitmap drawers.
REQ-015 The block SHALL have port gameFreeze, output, 1: high whenever the state is not PLAYING.
REQ-016 The block SHALL have port blinkOn, output, 1: blink phase for message drawing.
REQ-017 The block SHALL have port restartReq, output, 1: one-cycle pulse requesting game/score reset.

Function
REQ-018 The FSM SHALL have the states IDLE, READY, PLAYING, HIT, GAME_OVER and WIN.
REQ-019 In IDLE, message SHALL be 00, and gameStart SHALL move the FSM to READY.
REQ-020 In READY, message SHALL be 01, and the FSM SHALL move to PLAYING on the READY_FRAMES-th startOfFrame counted in the state.
REQ-021 In PLAYING, message SHALL be 00; playerHit SHALL move the FSM to HIT; otherwise levelCleared SHALL move it to WIN if lastLevel, else to READY.
REQ-022 When playerHit and levelCleared arrive in the same cycle, playerHit SHALL take priority.
REQ-023 In HIT, message SHALL be 00; after HIT_FRAMES frames the FSM SHALL move to GAME_OVER if livesZero, else to READY, with livesZero sampled on the exit cycle.
REQ-024 In GAME_OVER (message 10) and WIN (message 11), anyKey SHALL be ignored until the frame count reaches MIN_SHOW_FRAMES.
REQ-025 In GAME_OVER and WIN, once the frame count has reached MIN_SHOW_FRAMES, anyKey SHALL pulse restartReq for one cycle and move the FSM to IDLE.
REQ-026 Events not listed for the current state SHALL be ignored.
REQ-027 A single frame counter SHALL count startOfFrame pulses, clear on every state transition, and saturate at its maximum.
REQ-028 The frame counter SHALL be wide enough for the largest frame parameter.
REQ-029 message, gameFreeze, blinkOn and restartReq SHALL be registered, and each SHALL change on the clock edge that performs the transition (1-cycle latency from the event).
REQ-030 blinkOn SHALL be forced to 1 on entry to any state with a nonzero message.
REQ-031 blinkOn SHALL toggle every BLINK_FRAMES startOfFrame pulses while the message is nonzero, and SHALL be 1 while the message is 00.
REQ-032 A startOfFrame coinciding with a transition SHALL NOT count in the new state.

Reset
REQ-033 While resetN is low, the state SHALL be IDLE, the counter 0, message 00, gameFreeze 1, blinkOn 1 and restartReq 0, independent of clk.
REQ-034 A reset asserted mid-message SHALL abandon the message with no restartReq pulse.

Structure
REQ-035 The shared game package SHALL hold the message code enum (MSG_NONE, MSG_READY, MSG_GAMEOVER, MSG_WIN) and the default frame constants.
REQ-036 The FSM state enum SHALL be local to the module.
REQ-037 One sub-module, frame_counter (clear, startOfFrame increment, saturating count output), is natural and SHALL be used for both state timing and blink timing.

Verification (bench parameters READY_FRAMES=4, HIT_FRAMES=3, MIN_SHOW_FRAMES=5, BLINK_FRAMES=2)
REQ-038 Stimulus: gameStart, then 4 startOfFrame pulses. Required: message 01 from the next cycle; on the cycle after the 4th pulse, message 00 and gameFreeze 0.
REQ-039 Stimulus: in PLAYING, playerHit and levelCleared in the same cycle with livesZero=0. Required: state HIT; after 3 frames, message 01.
REQ-040 Stimulus: playerHit with livesZero=1, then 3 frames. Required: message 10; anyKey at frame 2 is ignored; anyKey at frame 5 gives restartReq high for exactly 1 cycle and message 00.
REQ-041 Stimulus: levelCleared with lastLevel=1. Required: message 11; blinkOn reads 1,1,0,0,1 over successive frames.
REQ-042 Stimulus: resetN low during WIN at frame 3. Required: message 00, gameFreeze 1 and restartReq 0 immediately, and IDLE after release.
